// File: rtl/tdp_bram_arbiter.sv
// tdp_bram_arbiter
//   Shares one true-dual-port BRAM (ports A/B, 1-cycle registered read) between NUM_REQ
//   requesters. A round-robin scan grants up to two requests per cycle, one per BRAM port,
//   and never lets the two ports collide on one address when either of them writes.
//
// Optional feature macro: TDP_ARB_FWD_EN
//   When defined, a read that collides only with the port-A write is still granted on port B
//   (which performs a plain read). Its response returns the write data (write-first forwarding).
//
// Ports
//   clk, rst             single clock, synchronous active-high reset
//   req_valid/we         per-requester request pending / write select
//   req_addr/wdata       packed request address / write data, requester i at slice i
//   req_ready            per-requester grant, combinational from req_valid
//   rsp_valid/rdata      per-requester read response, one cycle after the grant
//   a_a/we_a/wd_a/rd_a   BRAM port A address, write enable, write data, read data
//   a_b/we_b/wd_b/rd_b   BRAM port B address, write enable, write data, read data
module tdp_bram_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ABITS   = 10,
  parameter int unsigned DBITS   = 36
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ABITS-1:0]   req_addr,
  input  logic [NUM_REQ*DBITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [NUM_REQ*DBITS-1:0]   rsp_rdata,
  output logic [ABITS-1:0]           a_a,
  output logic                       we_a,
  output logic [DBITS-1:0]           wd_a,
  input  logic [DBITS-1:0]           rd_a,
  output logic [ABITS-1:0]           a_b,
  output logic                       we_b,
  output logic [DBITS-1:0]           wd_b,
  input  logic [DBITS-1:0]           rd_b
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [ABITS-1:0] addr      [NUM_REQ];
  logic [DBITS-1:0] wdata     [NUM_REQ];
  logic [DBITS-1:0] rdata_arr [NUM_REQ];
  logic [IW-1:0]    scan_idx  [NUM_REQ];

  logic [NUM_REQ-1:0] valid_m;
  logic [NUM_REQ-1:0] rd_gnt;
  logic [NUM_REQ-1:0] src_b;
  logic               gnt_a, gnt_b;
  logic [IW-1:0]      idx_a, idx_b;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [NUM_REQ-1:0] src_b_q;

`ifdef TDP_ARB_FWD_EN
  logic               fwd_b;
  logic               fwd_q;
  logic [DBITS-1:0]   fwd_data_q;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr[g]                       = req_addr[g*ABITS +: ABITS];
    assign wdata[g]                      = req_wdata[g*DBITS +: DBITS];
    assign rsp_rdata[g*DBITS +: DBITS]   = rdata_arr[g];
  end

  function automatic logic collide(logic [ABITS-1:0] addr_x, logic we_x,
                                   logic [ABITS-1:0] addr_y, logic we_y);
    return (addr_x == addr_y) && (we_x || we_y);
  endfunction

  function automatic logic [IW-1:0] wrap_inc(logic [IW-1:0] v);
    if (v == IW'(NUM_REQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  // Requesters in scan order, starting at ptr and wrapping modulo NUM_REQ.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (32'(ptr_q) + k >= NUM_REQ) scan_idx[k] = IW'(32'(ptr_q) + k - NUM_REQ);
      else                           scan_idx[k] = IW'(32'(ptr_q) + k);
    end
  end

  // Reset masks every grant in the cycle it is asserted.
  assign valid_m = rst ? '0 : req_valid;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    idx_a = '0;
    idx_b = '0;
`ifdef TDP_ARB_FWD_EN
    fwd_b = 1'b0;
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (valid_m[scan_idx[k]]) begin
        if (!gnt_a) begin
          gnt_a = 1'b1;
          idx_a = scan_idx[k];
        end else if (!gnt_b) begin
          if (!collide(addr[scan_idx[k]], req_we[scan_idx[k]], addr[idx_a], req_we[idx_a])) begin
            gnt_b = 1'b1;
            idx_b = scan_idx[k];
          end
`ifdef TDP_ARB_FWD_EN
          // Read hitting the port-A write: port B reads, the response takes the write data.
          else if (req_we[idx_a] && !req_we[scan_idx[k]]) begin
            gnt_b = 1'b1;
            idx_b = scan_idx[k];
            fwd_b = 1'b1;
          end
`endif
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    src_b     = '0;
    if (gnt_a) req_ready[idx_a] = 1'b1;
    if (gnt_b) begin
      req_ready[idx_b] = 1'b1;
      src_b[idx_b]     = 1'b1;
    end
    rd_gnt = req_ready & ~req_we;
  end

  always_comb begin
    a_a  = '0;
    we_a = 1'b0;
    wd_a = '0;
    a_b  = '0;
    we_b = 1'b0;
    wd_b = '0;
    if (gnt_a) begin
      a_a  = addr[idx_a];
      we_a = req_we[idx_a];
      wd_a = wdata[idx_a];
    end
    if (gnt_b) begin
      a_b  = addr[idx_b];
      we_b = req_we[idx_b];
      wd_b = wdata[idx_b];
    end
  end

  // Pointer moves past the last requester granted in scan order (port B if used).
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_b)      ptr_d = wrap_inc(idx_b);
    else if (gnt_a) ptr_d = wrap_inc(idx_a);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      src_b_q     <= '0;
`ifdef TDP_ARB_FWD_EN
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rd_gnt;
      src_b_q     <= src_b;
`ifdef TDP_ARB_FWD_EN
      fwd_q       <= fwd_b;
      fwd_data_q  <= wdata[idx_a];
`endif
    end
  end

  // A reset arriving right after a read grant suppresses that read's response.
  assign rsp_valid = rsp_valid_q & {NUM_REQ{~rst}};

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rdata_arr[i] = '0;
      if (rsp_valid[i]) begin
        if (src_b_q[i]) begin
`ifdef TDP_ARB_FWD_EN
          rdata_arr[i] = fwd_q ? fwd_data_q : rd_b;
`else
          rdata_arr[i] = rd_b;
`endif
        end else begin
          rdata_arr[i] = rd_a;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdp_bram_arbiter.sv
// tb_tdp_bram_arbiter
//   Directed bench for tdp_bram_arbiter with a read-first TDP BRAM model. Grants and port
//   drives are checked in the cycle they occur; read responses go through a scoreboard queue
//   that a monitor drains whenever rsp_valid is seen. Honors TDP_ARB_FWD_EN.
module tb_tdp_bram_arbiter;

  localparam int NR = 4;
  localparam int AB = 10;
  localparam int DB = 36;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AB-1:0]  req_addr;
  logic [NR*DB-1:0]  req_wdata, rsp_rdata;
  logic [AB-1:0]     a_a, a_b;
  logic              we_a, we_b;
  logic [DB-1:0]     wd_a, wd_b, rd_a, rd_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int            idx;
    logic [DB-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  tdp_bram_arbiter #(.NUM_REQ(NR), .ABITS(AB), .DBITS(DB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .a_a(a_a), .we_a(we_a), .wd_a(wd_a), .rd_a(rd_a),
    .a_b(a_b), .we_b(we_b), .wd_b(wd_b), .rd_b(rd_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-first TDP BRAM; location n initialised to 0x1_0000_0000 + n.
  logic [DB-1:0] mem [1024];
  initial begin
    for (int n = 0; n < 1024; n++) mem[n] = 36'h1_0000_0000 + DB'(n);
    forever begin
      @(posedge clk);
      if (we_a) mem[a_a] <= wd_a;
      if (we_b) mem[a_b] <= wd_b;
      rd_a <= mem[a_a];
      rd_b <= mem[a_b];
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_rsp(int i, logic [DB-1:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic set_req(int i, logic v, logic we, logic [AB-1:0] ad, logic [DB-1:0] wd);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*AB +: AB]   = ad;
    req_wdata[i*DB +: DB]  = wd;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    step();
    rst = 1'b0;
  endtask

  // Response monitor and cross-port collision watch.
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rsp_valid[i] === 1'b1) begin
        int found;
        found = -1;
        for (int k = 0; k < sb.size(); k++) begin
          if (sb[k].idx == i) begin
            found = k;
            break;
          end
        end
        if (found < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: requester %0d rsp_valid=1 with nothing pending (cycle %0d)",
                   i, cyc);
        end else begin
          chk($sformatf("rsp_data[%0d]", i), 64'(rsp_rdata[i*DB +: DB]), 64'(sb[found].data));
          chk($sformatf("rsp_cycle[%0d]", i), 64'(cyc), 64'(sb[found].due));
          sb.delete(found);
        end
      end
    end
    if ($countones(req_ready) == 2) begin
      logic bad;
      bad = (a_a == a_b) && (we_a || we_b);
`ifdef TDP_ARB_FWD_EN
      if (we_a && !we_b) bad = 1'b0;
`endif
      chk("no_collision", 64'(bad), 64'(0));
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

    // Reset with every requester asking: nothing granted, nothing written.
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AB'(10'h10 + i), '0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_we", 64'({we_a, we_b}), 64'h0);
      step();
    end
    rst = 1'b0;

    // Round-robin over four held reads.
    @(negedge clk);
    chk("rr0_ready", 64'(req_ready), 64'b0011);
    chk("rr0_ports", 64'({a_a, a_b}), 64'({10'h10, 10'h11}));
    expect_rsp(0, 36'h1_0000_0010);
    expect_rsp(1, 36'h1_0000_0011);
    step();
    @(negedge clk);
    chk("rr1_ready", 64'(req_ready), 64'b1100);
    chk("rr1_ports", 64'({a_a, a_b}), 64'({10'h12, 10'h13}));
    expect_rsp(2, 36'h1_0000_0012);
    expect_rsp(3, 36'h1_0000_0013);
    step();
    @(negedge clk);
    chk("rr2_ready", 64'(req_ready), 64'b0011);
    expect_rsp(0, 36'h1_0000_0010);
    expect_rsp(1, 36'h1_0000_0011);
    step();
    clear_all();
    @(negedge clk);
    chk("rr_idle_ready", 64'(req_ready), 64'h0);
    step();

    // Write-write collision on 0x55.
    do_reset();
    set_req(0, 1'b1, 1'b1, 10'h55, 36'hA5A5);
    set_req(1, 1'b1, 1'b1, 10'h55, 36'h5A5A);
    @(negedge clk);
    chk("ww0_ready", 64'(req_ready), 64'b0001);
    chk("ww0_port_a", 64'({we_a, a_a}), 64'({1'b1, 10'h55}));
    chk("ww0_we_b", 64'(we_b), 64'h0);
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("ww1_ready", 64'(req_ready), 64'b0010);
    chk("ww1_port_a", 64'({we_a, wd_a}), 64'({1'b1, 36'h5A5A}));
    step();
    set_req(1, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b1, 1'b0, 10'h55, '0);
    @(negedge clk);
    chk("ww_rb_ready", 64'(req_ready), 64'b0100);
    expect_rsp(2, 36'h5A5A);
    step();
    clear_all();
    @(negedge clk);
    step();

    // Write/read collision on 0x20.
    do_reset();
    set_req(0, 1'b1, 1'b1, 10'h20, 36'h123);
    set_req(1, 1'b1, 1'b0, 10'h20, '0);
    @(negedge clk);
`ifdef TDP_ARB_FWD_EN
    chk("wr0_ready", 64'(req_ready), 64'b0011);
    chk("wr0_ports", 64'({we_a, we_b, a_b}), 64'({1'b1, 1'b0, 10'h20}));
    expect_rsp(1, 36'h123);
    step();
    clear_all();
`else
    chk("wr0_ready", 64'(req_ready), 64'b0001);
    step();
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("wr1_ready", 64'(req_ready), 64'b0010);
    chk("wr1_port_a", 64'({we_a, a_a}), 64'({1'b0, 10'h20}));
    expect_rsp(1, 36'h123);
    step();
    clear_all();
`endif
    @(negedge clk);
    step();

    // Read-read to the same address on both ports.
    do_reset();
    set_req(2, 1'b1, 1'b0, 10'h30, '0);
    set_req(3, 1'b1, 1'b0, 10'h30, '0);
    @(negedge clk);
    chk("rrsame_ready", 64'(req_ready), 64'b1100);
    chk("rrsame_ports", 64'({a_a, a_b}), 64'({10'h30, 10'h30}));
    expect_rsp(2, 36'h1_0000_0030);
    expect_rsp(3, 36'h1_0000_0030);
    step();
    clear_all();
    @(negedge clk);
    step();

    // Reset right after a read grant: no response, pointer back to 0.
    do_reset();
    set_req(0, 1'b1, 1'b0, 10'h40, '0);
    @(negedge clk);
    chk("mid_grant", 64'(req_ready), 64'b0001);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("mid_ready", 64'(req_ready), 64'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, AB'(10'h10 + i), '0);
    @(negedge clk);
    chk("mid_ptr0_ready", 64'(req_ready), 64'b0011);
    expect_rsp(0, 36'h1_0000_0010);
    expect_rsp(1, 36'h1_0000_0011);
    step();
    clear_all();
    repeat (3) step();

    // Anything left in the scoreboard never got its response.
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_rsp: requester %0d got no response, expected %0h by cycle %0d",
               sb[0].idx, sb[0].data, sb[0].due);
      void'(sb.pop_front());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
